// File: rtl/tdm_demux8.sv
// tdm_demux8: receive end of an 8-channel TDM link.
// Locks onto a frame marker, steers each valid beat into its channel slot,
// and publishes all channels in parallel once per complete frame.
//
// Ports:
//   clk, rst_n   clock (rising edge) and async active-low reset
//   din          serial lane sample for the current slot
//   din_valid    din carries a slot beat; low stalls the frame
//   frame_sync   marks the current beat as slot 0 (only with din_valid)
//   dout         last complete frame, channel k at dout[k*DATA_W +: DATA_W]
//   frame_valid  one-cycle pulse when dout is updated
//   sync_err     one-cycle pulse on an alignment violation
//   locked       high while aligned to the frame marker
//   slot         next expected slot index
//   frame_cnt    completed frames, wraps at 255

// Per-channel storage: a shadow sample being assembled and the published
// output sample. The last channel publishes the live beat instead of its
// shadow so a frame completes on the edge that samples slot 7.
module tdm_demux8_lane #(
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              wr,
  input  logic              ld,
  input  logic              last,
  output logic [DATA_W-1:0] q
);
  logic [DATA_W-1:0] shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      q      <= '0;
    end else begin
      if (wr) shadow <= din;
      if (ld) q <= last ? din : shadow;
    end
  end
endmodule

module tdm_demux8 #(
  parameter int DATA_W = 1,
  parameter int NUM_CH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        din,
  input  logic                     din_valid,
  input  logic                     frame_sync,
  output logic [NUM_CH*DATA_W-1:0] dout,
  output logic                     frame_valid,
  output logic                     sync_err,
  output logic                     locked,
  output logic [2:0]               slot,
  output logic [7:0]               frame_cnt
);
  localparam logic [2:0] LAST = 3'(NUM_CH - 1);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t state, state_nxt;
  logic [2:0] slot_nxt;
  logic [NUM_CH-1:0] wr;
  logic ld, fv_nxt, err_nxt;
  logic [NUM_CH-1:0][DATA_W-1:0] lane_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      slot        <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      slot        <= slot_nxt;
      frame_valid <= fv_nxt;
      sync_err    <= err_nxt;
      if (fv_nxt) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    slot_nxt  = slot;
    wr        = '0;
    ld        = 1'b0;
    fv_nxt    = 1'b0;
    err_nxt   = 1'b0;
    if (din_valid) begin
      unique case (state)
        HUNT: begin
          if (frame_sync) begin
            wr[0]     = 1'b1;
            slot_nxt  = 3'd1;
            state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          if (frame_sync) begin
            // marker anywhere but slot 0 drops the partial frame and realigns
            err_nxt  = (slot != 3'd0);
            wr[0]    = 1'b1;
            slot_nxt = 3'd1;
          end else if (slot == 3'd0) begin
            // expected a marker and got none: lose lock, discard the beat
            err_nxt   = 1'b1;
            state_nxt = HUNT;
          end else begin
            wr[slot] = 1'b1;
            if (slot == LAST) begin
              ld       = 1'b1;
              fv_nxt   = 1'b1;
              slot_nxt = 3'd0;
            end else begin
              slot_nxt = slot + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    tdm_demux8_lane #(.DATA_W(DATA_W)) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (din),
      .wr   (wr[k]),
      .ld   (ld),
      .last (k == NUM_CH - 1),
      .q    (lane_q[k])
    );
  end

  assign dout   = lane_q;
  assign locked = (state == LOCKED);
endmodule

// File: tb/tb_tdm_demux8.sv
module tb_tdm_demux8;
  logic       clk, rst_n;
  logic [0:0] din;
  logic       din_valid, frame_sync;
  logic [7:0] dout;
  logic       frame_valid, sync_err, locked;
  logic [2:0] slot;
  logic [7:0] frame_cnt;

  tdm_demux8 #(.DATA_W(1), .NUM_CH(8)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .frame_sync(frame_sync), .dout(dout), .frame_valid(frame_valid),
    .sync_err(sync_err), .locked(locked), .slot(slot), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       fv, err, lk;
    logic [2:0] sl;
    logic [7:0] dout, cnt;
  } exp_t;

  exp_t exp_q[$];
  int errors = 0, checks = 0;

  // reference: frame held as a list of collected samples
  bit         m_locked;
  logic       m_buf[$];
  logic [7:0] m_dout, m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_buf.delete(); m_dout = '0; m_cnt = '0;
  endtask

  // drive one cycle at the falling edge, predict the outcome of the next rising edge
  task automatic beat(input bit v, input bit s, input logic d);
    exp_t e;
    @(negedge clk);
    din_valid = v; frame_sync = s; din = d;
    e = '0;
    if (v) begin
      if (!m_locked) begin
        if (s) begin m_buf.delete(); m_buf.push_back(d); m_locked = 1; end
      end else if (s) begin
        e.err = (m_buf.size() != 0);
        m_buf.delete(); m_buf.push_back(d);
      end else if (m_buf.size() == 0) begin
        e.err = 1; m_locked = 0;
      end else begin
        m_buf.push_back(d);
        if (m_buf.size() == 8) begin
          for (int k = 0; k < 8; k++) m_dout[k] = m_buf[k];
          m_cnt++; e.fv = 1; m_buf.delete();
        end
      end
    end
    e.lk = m_locked; e.sl = 3'(m_buf.size());
    e.dout = m_dout; e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] f);
    for (int k = 0; k < 8; k++) beat(1, k == 0, f[k]);
  endtask

  // monitor: pops one prediction per rising edge while out of reset
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("frame_valid", 32'(frame_valid), 32'(e.fv));
        chk("sync_err", 32'(sync_err), 32'(e.err));
        chk("locked", 32'(locked), 32'(e.lk));
        chk("slot", 32'(slot), 32'(e.sl));
        chk("dout", 32'(dout), 32'(e.dout));
        chk("frame_cnt", 32'(frame_cnt), 32'(e.cnt));
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] cnt0;
    rst_n = 0; din = '0; din_valid = 0; frame_sync = 0;
    model_reset();
    @(posedge clk); @(negedge clk);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_flags", {frame_valid, sync_err, locked}, 0);
    chk("rst_slot", 32'(slot), 0);
    chk("rst_cnt", 32'(frame_cnt), 0);
    rst_n = 1;

    // unmarked beats while hunting are discarded
    for (int i = 0; i < 5; i++) beat(1, 0, 1);

    // aligned frame x0..x7 = 1,0,1,0,1,0,1,1
    send_frame(8'b11010101);
    beat(0, 0, 0);
    chk("aligned_dout", 32'(dout), 32'hD5);
    chk("aligned_cnt", 32'(frame_cnt), 1);

    // same frame with a 3-cycle stall after slot 3
    for (int k = 0; k < 4; k++) beat(1, k == 0, 8'hD5 >> k);
    for (int i = 0; i < 3; i++) begin
      beat(0, 1, 1);
      chk("stall_slot", 32'(slot), 4);
    end
    for (int k = 4; k < 8; k++) beat(1, 0, 8'hD5 >> k);
    beat(0, 0, 0);
    chk("stall_dout", 32'(dout), 32'hD5);

    // early marker at slot 5, then 7 zero beats
    for (int k = 0; k < 5; k++) beat(1, k == 0, 1);
    beat(1, 1, 0);
    for (int k = 0; k < 6; k++) beat(1, 0, 0);
    chk("early_hold", 32'(dout), 32'hD5);
    beat(1, 0, 0);
    beat(0, 0, 0);
    chk("early_dout", 32'(dout), 32'h00);

    // missing marker after a complete frame
    beat(1, 0, 1);
    beat(0, 0, 0);
    chk("miss_locked", 32'(locked), 0);
    for (int i = 0; i < 10; i++) beat(1, 0, 1);
    send_frame(8'hFF);
    beat(0, 0, 0);
    chk("miss_dout", 32'(dout), 32'hFF);

    // async reset in the middle of a frame
    send_frame(8'h3C);
    for (int k = 0; k < 3; k++) beat(1, k == 0, 1);
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    chk("arst_dout", 32'(dout), 0);
    chk("arst_slot", 32'(slot), 0);
    chk("arst_locked", 32'(locked), 0);
    chk("arst_cnt", 32'(frame_cnt), 0);
    din_valid = 0;
    model_reset(); exp_q.delete();
    @(posedge clk); @(negedge clk);
    rst_n = 1;
    send_frame(8'hA5);
    beat(0, 0, 0);
    chk("rerun_dout", 32'(dout), 32'hA5);
    chk("rerun_cnt", 32'(frame_cnt), 1);

    // 256 back-to-back frames wrap the counter
    cnt0 = frame_cnt;
    for (int f = 0; f < 256; f++) send_frame(8'($urandom));
    beat(0, 0, 0);
    chk("wrap_cnt", 32'(frame_cnt), 32'(cnt0));

    // random traffic with occasional stalls and misplaced markers
    for (int i = 0; i < 3000; i++) begin
      bit v, s;
      v = ($urandom % 5) != 0;
      if (m_buf.size() == 0) s = ($urandom % 10) != 0;
      else s = ($urandom % 16) == 0;
      beat(v, s, 1'($urandom));
    end
    for (int i = 0; i < 3; i++) beat(0, 0, 0);
    @(posedge clk); #2;
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
